// File: rtl/test_stats_sequencer.sv
// test_stats_sequencer
//   Collects pass/fail results from NUM_REQ checker channels through a
//   round-robin arbiter into shared counters. The run closes after ITERATIONS
//   results or an early stop; then floor(pass*100/total) is computed by a
//   7-step restoring divider and held in DONE until the next start.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, stop        run control pulses
//   req_valid/req_fail per-channel result handshake (1=fail)
//   req_ready          one-hot grant, combinational, only in COLLECT
//   pass/fail/total_count, pct_pass   run statistics
//   busy, done         status (COLLECT|DIVIDE, DONE)
//   first_fail_*       first failing channel/iteration capture
//
// Optional feature macro: STATS_FIRST_FAIL_EN (first-fail capture registers).
module test_stats_sequencer #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ITERATIONS = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_fail,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [CNT_W-1:0]   pass_count,
    output logic [CNT_W-1:0]   fail_count,
    output logic [CNT_W-1:0]   total_count,
    output logic [6:0]         pct_pass,
    output logic               busy,
    output logic               done,
    output logic               first_fail_valid,
    output logic [2:0]         first_fail_id,
    output logic [CNT_W-1:0]   first_fail_iter
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DW = CNT_W + 7;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DIVIDE, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_ptr;
    logic [CNT_W-1:0]   r_pass, r_fail, r_total;
    logic [6:0]         r_pct;
    logic [6:0]         r_q;
    logic [DW-1:0]      r_rem;
    logic [2:0]         r_div_cnt;

    logic               w_found, w_gfail;
    logic [PW-1:0]      w_gidx, w_ptr_nxt;
    logic               w_accept, w_last, w_clear, w_tot_zero;
    logic [DW-1:0]      w_rem_in, w_divisor, w_rem_sub;
    logic               w_qbit;

    // Round-robin search: lowest valid index at/above the pointer wins,
    // otherwise the lowest valid index below it (wrap-around).
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_gfail = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (i >= 32'(r_ptr))) begin
                w_found = 1'b1;
                w_gidx  = PW'(i);
                w_gfail = req_fail[i];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i] && (i < 32'(r_ptr))) begin
                w_found = 1'b1;
                w_gidx  = PW'(i);
                w_gfail = req_fail[i];
            end
        end
    end

    assign w_accept   = (r_state == S_COLLECT) && w_found;
    assign w_last     = w_accept && (r_total == CNT_W'(ITERATIONS - 1));
    assign w_clear    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_tot_zero = (r_total == '0);
    assign w_ptr_nxt  = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);

    // Divider step: the first step reads pass*100 directly so the dividend
    // reflects an accept on the closing edge. Quotient never exceeds 100,
    // so starting with divisor<<6 yields all 7 bits.
    assign w_rem_in  = (r_div_cnt == 3'd0) ? DW'(r_pass) * DW'(100) : r_rem;
    assign w_divisor = DW'(r_total) << (3'd6 - r_div_cnt);
    assign w_qbit    = (w_rem_in >= w_divisor);
    assign w_rem_sub = w_qbit ? (w_rem_in - w_divisor) : w_rem_in;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_COLLECT;
            S_COLLECT:      if (stop || w_last) w_state_nxt = S_DIVIDE;
            S_DIVIDE:       if (w_tot_zero || (r_div_cnt == 3'd6)) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (r_state == S_COLLECT) || (r_state == S_DIVIDE);
        done      = (r_state == S_DONE);
        req_ready = '0;
        if (w_accept) req_ready = NUM_REQ'(1) << w_gidx;
    end

    // Counters, pointer and divider datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_total   <= '0;
            r_pct     <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_div_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_clear) begin
                        r_pass  <= '0;
                        r_fail  <= '0;
                        r_total <= '0;
                        r_pct   <= '0;
                    end
                    r_div_cnt <= '0;
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        if (w_gfail) r_fail <= r_fail + CNT_W'(1);
                        else         r_pass <= r_pass + CNT_W'(1);
                        r_total <= r_total + CNT_W'(1);
                        r_ptr   <= w_ptr_nxt;
                    end
                    r_div_cnt <= '0;
                end
                S_DIVIDE: begin
                    if (w_tot_zero) begin
                        r_pct <= '0;
                    end else begin
                        r_rem     <= w_rem_sub;
                        r_q       <= {r_q[5:0], w_qbit};
                        r_div_cnt <= r_div_cnt + 3'd1;
                        if (r_div_cnt == 3'd6) r_pct <= {r_q[5:0], w_qbit};
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass_count  = r_pass;
    assign fail_count  = r_fail;
    assign total_count = r_total;
    assign pct_pass    = r_pct;

`ifdef STATS_FIRST_FAIL_EN
    logic             r_ff_valid;
    logic [2:0]       r_ff_id;
    logic [CNT_W-1:0] r_ff_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_valid <= 1'b0;
            r_ff_id    <= '0;
            r_ff_iter  <= '0;
        end else if (w_clear) begin
            r_ff_valid <= 1'b0;
            r_ff_id    <= '0;
            r_ff_iter  <= '0;
        end else if (w_accept && w_gfail && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_id    <= 3'(w_gidx);
            r_ff_iter  <= r_total;
        end
    end

    assign first_fail_valid = r_ff_valid;
    assign first_fail_id    = r_ff_id;
    assign first_fail_iter  = r_ff_iter;
`else
    assign first_fail_valid = 1'b0;
    assign first_fail_id    = '0;
    assign first_fail_iter  = '0;
`endif

endmodule

// File: tb/tb_test_stats_sequencer.sv
module tb_test_stats_sequencer;

    localparam int NR = 4;
    localparam int CW = 16;
    localparam int IT = 10;
`ifdef STATS_FIRST_FAIL_EN
    localparam int FF = 1;
`else
    localparam int FF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_fail = '0;
    logic [NR-1:0] req_ready;
    logic [CW-1:0] pass_count, fail_count, total_count, first_fail_iter;
    logic [6:0]    pct_pass;
    logic          busy, done, first_fail_valid;
    logic [2:0]    first_fail_id;

    test_stats_sequencer #(
        .NUM_REQ   (NR),
        .CNT_W     (CW),
        .ITERATIONS(IT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stop            (stop),
        .req_valid       (req_valid),
        .req_fail        (req_fail),
        .req_ready       (req_ready),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .total_count     (total_count),
        .pct_pass        (pct_pass),
        .busy            (busy),
        .done            (done),
        .first_fail_valid(first_fail_valid),
        .first_fail_id   (first_fail_id),
        .first_fail_iter (first_fail_iter)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int p, f, t, pct, ffv, ffid, ffit, dcyc;
    } sum_t;

    int   gq[$];
    sum_t sq[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic void check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Monitor: pops expected grants on each accept and expected run
    // summaries when done rises.
    logic prev_done = 1'b0;
    int   m_e;
    sum_t m_s;
    always @(negedge clk) begin
        if (rst_n) begin
            if ((req_valid & req_ready) != '0) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", int'(req_ready), 0);
                end else begin
                    m_e = gq.pop_front();
                    check("grant_onehot", int'(req_ready), 1 << m_e);
                end
            end
            if (done && !prev_done) begin
                if (sq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    m_s = sq.pop_front();
                    check("pass_count",  int'(pass_count),  m_s.p);
                    check("fail_count",  int'(fail_count),  m_s.f);
                    check("total_count", int'(total_count), m_s.t);
                    check("pct_pass",    int'(pct_pass),    m_s.pct);
                    check("ff_valid",    int'(first_fail_valid), m_s.ffv);
                    check("ff_id",       int'(first_fail_id),    m_s.ffid);
                    check("ff_iter",     int'(first_fail_iter),  m_s.ffit);
                    check("done_cycle",  cyc, m_s.dcyc);
                end
            end
        end
        prev_done <= done & rst_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_ready(input int ch);
        bit got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1'b1;
        end
        if (!got) check("grant_timeout", 0, 1);
    endtask

    // One result on one channel; acc returns the cycle the accept was presented.
    task automatic send(input int ch, input bit f, output int acc);
        gq.push_back(ch);
        req_valid[ch] = 1'b1;
        req_fail[ch]  = f;
        wait_ready(ch);
        acc = cyc;
        step();
        req_valid[ch] = 1'b0;
        req_fail[ch]  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit got = 1'b0;
        for (int t = 0; t < limit && !got; t++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) check("done_timeout", 0, 1);
        step();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_pass"},  int'(pass_count), 0);
        check({tag, "_fail"},  int'(fail_count), 0);
        check({tag, "_total"}, int'(total_count), 0);
        check({tag, "_pct"},   int'(pct_pass), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_ready"}, int'(req_ready), 0);
        check({tag, "_ffv"},   int'(first_fail_valid), 0);
        check({tag, "_ffit"},  int'(first_fail_iter), 0);
    endtask

    int acc;

    initial begin
        // Reset state, and no grant outside COLLECT
        step();
        step();
        check_zero("reset");
        rst_n = 1'b1;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("ready_idle", int'(req_ready), 0);
        step();
        req_valid[0] = 1'b0;

        // 7 passes + 3 fails on channel 0: automatic close at ITERATIONS
        pulse_start();
        for (int i = 0; i < IT; i++) send(0, (i >= 7), acc);
        sq.push_back('{7, 3, 10, 70, FF, 0, 7 * FF, acc + 8});
        req_valid[1] = 1'b1;          // must not be granted after close
        step();
        check("busy_divide", int'(busy), 1);
        check("pct_while_busy", int'(pct_pass), 0);
        pulse_start();                // ignored in DIVIDE
        wait_done(20);
        req_valid[1] = 1'b0;
        stop = 1'b1;                  // ignored in DONE
        step();
        stop = 1'b0;
        step();
        check("done_hold", int'(done), 1);
        check("pct_hold", int'(pct_pass), 70);

        // Reset from DONE clears everything, pointer back to 0
        rst_n = 1'b0;
        #1;
        check("reset_done_done", int'(done), 0);
        check("reset_done_pct", int'(pct_pass), 0);
        step();
        rst_n = 1'b1;

        // All channels valid for 8 cycles: strict rotation
        pulse_start();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NR; c++) gq.push_back(c);
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        stop = 1'b1;
        acc = cyc;
        step();
        stop = 1'b0;
        sq.push_back('{8, 0, 8, 100, 0, 0, 0, acc + 8});
        wait_done(20);

        // Pointer to 2 via a grant on 1, then 1 and 3 together: 3 wins first;
        // then a fail on 2 together with stop is still counted
        pulse_start();
        send(1, 1'b0, acc);
        gq.push_back(3);
        gq.push_back(1);
        req_valid = 4'b1010;
        wait_ready(3);
        step();
        req_valid[3] = 1'b0;
        wait_ready(1);
        step();
        req_valid[1] = 1'b0;
        stop = 1'b1;
        send(2, 1'b1, acc);
        stop = 1'b0;
        sq.push_back('{3, 1, 4, 75, FF, 2 * FF, 3 * FF, acc + 8});
        wait_done(20);

        // Stop with nothing accepted: one DIVIDE cycle, pct 0
        pulse_start();
        stop = 1'b1;
        acc = cyc;
        step();
        stop = 1'b0;
        sq.push_back('{0, 0, 0, 0, 0, 0, 0, acc + 2});
        wait_done(10);

        // 1 pass of 3: floor(100/3) = 33
        pulse_start();
        send(0, 1'b0, acc);
        send(1, 1'b1, acc);
        stop = 1'b1;
        send(2, 1'b1, acc);
        stop = 1'b0;
        sq.push_back('{1, 2, 3, 33, FF, FF, FF, acc + 8});
        wait_done(20);

        // Reset in the middle of DIVIDE discards the run
        pulse_start();
        send(0, 1'b0, acc);
        send(0, 1'b0, acc);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        step();
        check("busy_mid_divide", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("reset_divide");
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("idle_after_reset_done", int'(done), 0);
        check("idle_after_reset_busy", int'(busy), 0);

        check("grant_queue_empty", gq.size(), 0);
        check("summary_queue_empty", sq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/test_stats_sequencer.md
Name: test_stats_sequencer

Overview:
Hardware result collector for self-checking benches and on-chip BIST. Arbitrates pass/fail result submissions from NUM_REQ checker channels into one shared set of statistics counters. Closes the run after ITERATIONS results or an early stop. Computes integer percentage pass as floor(pass*100/total) with a multi-cycle divider and holds the summary until the next start.

Parameters:
NUM_REQ, 4, number of checker channels (2..8)
CNT_W, 16, width of pass/fail/total counters; ITERATIONS must be < 2**CNT_W
ITERATIONS, 1000, results accepted before automatic close (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear counters, begin collection (honoured in IDLE or DONE only)
stop  in  1  pulse: close run early (honoured in COLLECT only)
req_valid  in  NUM_REQ  per-channel result valid
req_fail  in  NUM_REQ  per-channel result: 1=fail, 0=pass
req_ready  out  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
pass_count  out  CNT_W  accepted passes
fail_count  out  CNT_W  accepted failures
total_count  out  CNT_W  pass_count+fail_count
pct_pass  out  7  floor(pass_count*100/total_count), 0..100
busy  out  1  high in COLLECT and DIVIDE
done  out  1  high in DONE
first_fail_valid  out  1  optional feature, see below
first_fail_id  out  3  optional feature
first_fail_iter  out  CNT_W  optional feature

Behaviour:
- Reset: state=IDLE; all counters, pct_pass, busy, done, first_fail_* = 0; RR pointer = 0; req_ready = 0.
- States: IDLE, COLLECT, DIVIDE, DONE.
- IDLE/DONE + start: clear counters, pct_pass and first_fail_*; next cycle COLLECT. DONE without start holds all outputs.
- COLLECT: req_ready combinational one-hot. Grant goes to the first asserted req_valid searching upward from the RR pointer, with wrap-around. At most one accept per cycle.
- On accept: increment fail_count or pass_count and total_count at the same edge. RR pointer <= granted index + 1 mod NUM_REQ.
- Pointer is unchanged when nothing is accepted. A requester holds valid until it sees ready; a non-granted channel is not lost.
- Close: an accept that makes total_count == ITERATIONS -> DIVIDE next cycle. Requests after that are not granted.
- stop in COLLECT -> DIVIDE next cycle. An accept in the same cycle as stop is counted first.
- DIVIDE with total_count==0: pct_pass=0, go to DONE in 1 cycle.
- DIVIDE otherwise: restoring division of dividend pass_count*100 (CNT_W+7 bits) by total_count. Produces 7 quotient bits MSB-first, one per cycle.
- DIVIDE latency: exactly 7 cycles, then DONE. pct_pass is written on the DONE transition only; it reads 0 while busy.
- start or stop in DIVIDE: ignored. stop in IDLE/DONE: ignored.
- req_ready = 0 in every state except COLLECT.
- rst_n low at any point, including mid-COLLECT or mid-DIVIDE: immediate return to reset values; the partial run is discarded.

Optional Feature:
STATS_FIRST_FAIL_EN
- Defined: on the first accepted fail of a run, capture first_fail_id = granted index and first_fail_iter = total_count before increment (0-based). first_fail_valid is set to 1 at that edge. Later fails do not update the capture. Cleared by start and reset.
- Undefined: first_fail_valid, first_fail_id and first_fail_iter are tied to 0; no capture registers are built.

Test Plan:
- ITERATIONS=10, channel 0 only, 7 passes then 3 fails -> pass=7, fail=3, total=10; done 8 cycles after the 10th accept; pct_pass=70.
- All 4 channels hold valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; exactly one ready per cycle.
- Channels 1 and 3 valid, pointer=2 -> channel 3 granted first, then 1 (wrap-around).
- 3 passes, then stop asserted together with a 4th valid fail -> fail=1, total=4, pct_pass=75. stop at total=0 -> pct_pass=0, done after 1 cycle.
- ITERATIONS=3, 1 pass of 3 -> pct_pass=33 (floor). Assert rst_n low during DIVIDE -> all outputs 0, state IDLE.
- With STATS_FIRST_FAIL_EN defined: sequence P,P,F on ch2,F on ch0 -> first_fail_id=2, first_fail_iter=2, valid=1. Without the macro: all first_fail_* remain 0.
